nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter NIBBLES, default 4, operand width in 4-bit nibbles (legal 2..8); W = 4*NIBBLES.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 IN_VALID  input  1  requester presents an operand set.
REQ-005 IN_READY  output  1  block can accept an operand set.
REQ-006 A  input  W  operand A, sampled only on accept.
REQ-007 B  input  W  operand B, sampled only on accept.
REQ-008 CIN  input  1  carry-in, sampled only on accept.
REQ-009 OUT_VALID  output  1  SUM/COUT/OVF hold a completed result.
REQ-010 OUT_READY  input  1  consumer takes the result.
REQ-011 SUM  output  W  registered sum.
REQ-012 COUT  output  1  registered carry out of the MSB nibble.
REQ-013 OVF  output  1  registered two's-complement overflow.
REQ-014 BUSY  output  1  high in any non-IDLE state.

Function
REQ-015 Arithmetic SHALL use exactly one ic_7483 instance (A, B, C0 in; SUM, Cout out); one nibble per cycle; no other adder.
REQ-016 FSM states: IDLE, ADD, DONE; encoding free; no unreachable or illegal state may persist beyond one cycle (default -> IDLE).
REQ-017 IDLE: IN_READY=1, OUT_VALID=0; accept = IN_VALID & IN_READY at an edge; on accept latch A, B, CIN into operand registers, carry_reg <= CIN, idx <= 0, SUM <= 0, go ADD.
REQ-018 IN_READY SHALL be 0 in ADD and DONE; IN_VALID there is ignored and operands are not resampled.
REQ-019 ADD: adder inputs = nibble idx of latched A and B, C0 = carry_reg; each edge: SUM[4*idx+3:4*idx] <= adder SUM, carry_reg <= Cout, idx <= idx+1.
REQ-020 ADD -> DONE on the edge that writes nibble NIBBLES-1; on that edge COUT <= Cout and OVF <= (A[W-1] == B[W-1]) & (adder SUM[3] != A[W-1]) using latched operands.
REQ-021 Latency: accept at edge t -> OUT_VALID first high after edge t+NIBBLES; BUSY high after edges t .. until result taken.
REQ-022 DONE: OUT_VALID=1; SUM, COUT, OVF stable while OUT_VALID=1 and OUT_READY=0 (unbounded backpressure).
REQ-023 DONE & OUT_READY at an edge -> IDLE; IN_READY high next cycle; no same-cycle accept of a new operand set (min. one IDLE cycle between results).
REQ-024 SUM, COUT, OVF retain last result through IDLE and are overwritten only by the next accept/ADD sequence.
REQ-025 OUT_READY outside DONE has no effect.
REQ-026 idx width = ceil(log2(NIBBLES)); idx never exceeds NIBBLES-1.

Reset
REQ-027 rst high at an edge, in any state including mid-ADD or DONE: state <= IDLE, idx <= 0, carry_reg <= 0, SUM <= 0, COUT <= 0, OVF <= 0; any in-flight operation discarded, no result delivered.
REQ-028 During and after reset: IN_READY=1, OUT_VALID=0, BUSY=0; rst has priority over every handshake in the same cycle.

Verification (NIBBLES=4)
REQ-029 A=0x0001, B=0x0002, CIN=0 -> SUM=0x0003, COUT=0, OVF=0, OUT_VALID high exactly 4 edges after accept.
REQ-030 A=0xFFFF, B=0x0001, CIN=0 -> SUM=0x0000, COUT=1, OVF=0 (full ripple across all nibbles); A=0x7FFF, B=0x0001 -> SUM=0x8000, COUT=0, OVF=1.
REQ-031 A=0xFFFF, B=0xFFFF, CIN=1 -> SUM=0xFFFF, COUT=1, OVF=0; A=0xA5A5, B=0x5A5A, CIN=1 -> SUM=0x0000, COUT=1, OVF=0.
REQ-032 Backpressure: OUT_READY=0 for 10 cycles in DONE -> outputs stable, IN_READY=0; new IN_VALID with different A/B during ADD/DONE ignored; result matches first operands.
REQ-033 Reset mid-operation: accept 0x1234+0x1111, assert rst after 2 ADD edges -> next cycle IDLE, all outputs zero, no OUT_VALID; following 0x1234+0x1111 -> SUM=0x2345.
REQ-034 Back-to-back: OUT_READY and IN_VALID held high, 3 operand sets -> 3 correct results, each accept one cycle after prior handoff.

Source files
------------

// File: rtl/nibble_add_seq.sv
// Serial nibble adder: one operand set is added 4 bits per cycle through a single
// 7483-style adder, with valid/ready handshakes on both sides.

module ic_7483 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_c0,
  output logic [3:0] o_sum,
  output logic       o_cout
);
  logic [4:0] w_total;

  assign w_total = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_c0};
  assign o_sum   = w_total[3:0];
  assign o_cout  = w_total[4];
endmodule

module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [4*NIBBLES-1:0] i_a,
  input  logic [4*NIBBLES-1:0] i_b,
  input  logic                 i_cin,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [4*NIBBLES-1:0] o_sum,
  output logic                 o_cout,
  output logic                 o_ovf,
  output logic                 o_busy
);
  // state | meaning
  // IDLE  | waiting for an operand set, last result held on o_sum/o_cout/o_ovf
  // ADD   | adding nibble r_idx, LSB first
  // DONE  | result valid, waiting for consumer
  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t        r_state;
  logic [W-1:0]  r_a;
  logic [W-1:0]  r_b;
  logic          r_carry;
  logic [IW-1:0] r_idx;
  logic [W-1:0]  r_sum;
  logic          r_cout;
  logic          r_ovf;
  logic          r_in_ready;
  logic          r_out_valid;
  logic          r_busy;

  logic [W-1:0]  w_a_sh;
  logic [W-1:0]  w_b_sh;
  logic [3:0]    w_add_sum;
  logic          w_add_cout;

  assign w_a_sh = r_a >> {r_idx, 2'b00};
  assign w_b_sh = r_b >> {r_idx, 2'b00};

  ic_7483 u_adder (
    .i_a    (w_a_sh[3:0]),
    .i_b    (w_b_sh[3:0]),
    .i_c0   (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_a        <= i_a;
            r_b        <= i_b;
            r_carry    <= i_cin;
            r_idx      <= '0;
            r_sum      <= '0;
            r_state    <= S_ADD;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_ADD: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_add_sum;
          r_carry <= w_add_cout;
          if (r_idx == LAST_IDX) begin
            // idx parks at 0 so it never runs past the last nibble
            r_idx       <= '0;
            r_cout      <= w_add_cout;
            r_ovf       <= (r_a[W-1] == r_b[W-1]) & (w_add_sum[3] != r_a[W-1]);
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_busy      = r_busy;
  assign o_sum       = r_sum;
  assign o_cout      = r_cout;
  assign o_ovf       = r_ovf;
endmodule

// File: tb/tb_nibble_add_seq.sv
// Directed bench for nibble_add_seq (NIBBLES=4): arithmetic corners, latency,
// backpressure, mid-operation reset and back-to-back handshakes.

module tb_nibble_add_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  nibble_add_seq #(.NIBBLES(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .i_cin       (cin),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_sum       (sum),
    .o_cout      (cout),
    .o_ovf       (ovf),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_errors++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b, want 100", {in_ready, out_valid, busy});
    end
    n_checks++;
    if ({sum, cout, ovf} !== 18'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got sum=%h cout=%b ovf=%b, want 0", sum, cout, ovf);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_arith();
    logic [15:0] va [7] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'hFFFF, 16'hA5A5, 16'h8000, 16'h0F0F};
    logic [15:0] vb [7] = '{16'h0002, 16'h0001, 16'h0001, 16'hFFFF, 16'h5A5A, 16'h8000, 16'h00F1};
    logic        vc [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [15:0] es [7] = '{16'h0003, 16'h0000, 16'h8000, 16'hFFFF, 16'h0000, 16'h0000, 16'h1000};
    logic        ec [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        eo [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      int cnt;
      a = va[i]; b = vb[i]; cin = vc[i]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; a = 16'h0; b = 16'h0; cin = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, busy} !== 3'b001) begin
        n_errors++;
        $display("FAIL arith%0d_accept: got rdy/vld/busy=%b, want 001", i, {in_ready, out_valid, busy});
      end
      cnt = 1;
      while (!out_valid && cnt < 20) begin
        tick();
        if (!out_valid) cnt++;
      end
      n_checks++;
      if (cnt !== 4) begin
        n_errors++;
        $display("FAIL arith%0d_latency: got %0d edges, want 4", i, cnt);
      end
      n_checks++;
      if ({sum, cout, ovf} !== {es[i], ec[i], eo[i]}) begin
        n_errors++;
        $display("FAIL arith%0d_result: got sum=%h cout=%b ovf=%b, want sum=%h cout=%b ovf=%b",
                 i, sum, cout, ovf, es[i], ec[i], eo[i]);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      n_checks++;
      if ({in_ready, out_valid, busy, sum} !== {3'b100, es[i]}) begin
        n_errors++;
        $display("FAIL arith%0d_handoff: got rdy/vld/busy=%b sum=%h, want 100 sum=%h",
                 i, {in_ready, out_valid, busy}, sum, es[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    int cnt;
    a = 16'h1234; b = 16'h4321; cin = 1'b0; in_valid = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    n_checks++;
    if (!out_valid) begin
      n_errors++;
      $display("FAIL bp_timeout: out_valid=%b, want 1", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({out_valid, in_ready, busy, sum, cout, ovf} !== {3'b101, 16'h5555, 2'b00}) begin
        n_errors++;
        $display("FAIL bp_hold%0d: got vld/rdy/busy=%b sum=%h cout=%b ovf=%b, want 101 sum=5555 0 0",
                 i, {out_valid, in_ready, busy}, sum, cout, ovf);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      n_errors++;
      $display("FAIL bp_release: got rdy/vld=%b, want 10", {in_ready, out_valid});
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({in_ready, out_valid, busy, sum, cout, ovf} !== {3'b100, 16'h0, 2'b00}) begin
      n_errors++;
      $display("FAIL rstmid_state: got rdy/vld/busy=%b sum=%h cout=%b ovf=%b, want 100 all zero",
               {in_ready, out_valid, busy}, sum, cout, ovf);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL rstmid_novalid%0d: got out_valid=%b, want 0", i, out_valid);
      end
    end
    a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 20) begin
      tick();
      cnt++;
    end
    n_checks++;
    if ({out_valid, sum, cout, ovf} !== {1'b1, 16'h2345, 2'b00}) begin
      n_errors++;
      $display("FAIL rstmid_rerun: got vld=%b sum=%h cout=%b ovf=%b, want 1 2345 0 0",
               out_valid, sum, cout, ovf);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3] = '{16'h0F0F, 16'h8000, 16'h4000};
    logic [15:0] vb [3] = '{16'h00F1, 16'hFFFF, 16'h4000};
    logic        vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [17:0] ex [3] = '{{16'h1000, 2'b00}, {16'h8000, 2'b10}, {16'h8000, 2'b01}};
    int k_acc = 0;
    int k_res = 0;
    int last_handoff = -10;
    int cyc = 0;
    out_ready = 1'b1;
    a = va[0]; b = vb[0]; cin = vc[0]; in_valid = 1'b1;
    while (k_res < 3 && cyc < 80) begin
      logic acc;
      logic hand;
      acc  = in_ready & in_valid;
      hand = out_valid;
      if (hand) begin
        n_checks++;
        if ({sum, cout, ovf} !== ex[k_res]) begin
          n_errors++;
          $display("FAIL b2b_result%0d: got %h, want %h", k_res, {sum, cout, ovf}, ex[k_res]);
        end
      end
      tick();
      cyc++;
      if (hand) begin
        last_handoff = cyc;
        k_res++;
      end
      if (acc) begin
        if (k_acc > 0) begin
          n_checks++;
          if (cyc !== last_handoff + 1) begin
            n_errors++;
            $display("FAIL b2b_gap%0d: accept at %0d, want %0d", k_acc, cyc, last_handoff + 1);
          end
        end
        k_acc++;
        if (k_acc < 3) begin
          a = va[k_acc]; b = vb[k_acc]; cin = vc[k_acc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    n_checks++;
    if (k_res !== 3) begin
      n_errors++;
      $display("FAIL b2b_count: got %0d results, want 3", k_res);
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
